// File: rtl/bus_source_sequencer_pkg.sv
// Shared definitions for the common-bus source sequencer: source indices,
// FSM state encoding and default widths.
package bus_source_sequencer_pkg;

  localparam int DEF_BITS      = 16;
  localparam int DEF_ADDR_BITS = 12;

  localparam int SRC_ZERO = 0;
  localparam int SRC_AR   = 1;
  localparam int SRC_PC   = 2;
  localparam int SRC_DR   = 3;
  localparam int SRC_AC   = 4;
  localparam int SRC_IR   = 5;
  localparam int SRC_TR   = 6;
  localparam int SRC_MEM  = 7;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

endpackage

// File: rtl/bus_src_extract.sv
// Combinational source selector: picks source `sel` from the flattened source
// vector, zero-extending narrow (address-class) sources to the full bus width.
module bus_src_extract
  import bus_source_sequencer_pkg::*;
#(
  parameter int          BITS      = DEF_BITS,
  parameter int          ADDR_BITS = DEF_ADDR_BITS,
  parameter int          NSRC      = 8,
  parameter int          SEL_W     = 3,
  parameter logic [31:0] NARROW    = 32'h06
) (
  input  logic [SEL_W-1:0]     sel,
  input  logic [NSRC*BITS-1:0] src_data,
  output logic [BITS-1:0]      value
);

  // Source 0 and out-of-range selects fall through to the zero default.
  always_comb begin
    value = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        value = NARROW[i] ? BITS'(src_data[i*BITS +: ADDR_BITS])
                          : src_data[i*BITS +: BITS];
      end
    end
  end

  // Source 0 and the upper bits of narrow sources are deliberately ignored.
  logic unused_src_bits;
  assign unused_src_bits = ^src_data;

endmodule

// File: rtl/bus_source_sequencer.sv
// Registered common-bus source sequencer with request handshake, wait-stated
// memory source, illegal-select error and memory read timeout.
module bus_source_sequencer
  import bus_source_sequencer_pkg::*;
#(
  parameter int          BITS      = DEF_BITS,
  parameter int          ADDR_BITS = DEF_ADDR_BITS,
  parameter int          NSRC      = 8,
  parameter int          SEL_W     = 3,
  parameter logic [31:0] NARROW    = 32'h06,
  parameter int          MEM_SRC   = SRC_MEM,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [SEL_W-1:0]     req_sel,
  output logic                 req_ready,
  input  logic [NSRC*BITS-1:0] src_data,
  output logic                 mem_rd_req,
  input  logic                 mem_rd_ack,
  output logic [BITS-1:0]      bus,
  output logic                 bus_valid,
  output logic [SEL_W-1:0]     bus_src,
  output logic                 bus_err
);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [BITS-1:0]  bus_nxt;
  logic [SEL_W-1:0] bus_src_nxt;
  logic             bus_valid_nxt, bus_err_nxt, mem_rd_req_nxt;
  logic [SEL_W-1:0] ext_sel;
  logic [BITS-1:0]  ext_value;
  logic             accept;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;

  // While waiting on memory the extractor is steered to the memory source.
  assign ext_sel = (state == ST_WAIT_MEM) ? SEL_W'(MEM_SRC) : req_sel;

  bus_src_extract #(
    .BITS      (BITS),
    .ADDR_BITS (ADDR_BITS),
    .NSRC      (NSRC),
    .SEL_W     (SEL_W),
    .NARROW    (NARROW)
  ) u_extract (
    .sel      (ext_sel),
    .src_data (src_data),
    .value    (ext_value)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bus_nxt        = bus;
    bus_src_nxt    = bus_src;
    bus_valid_nxt  = 1'b0;
    bus_err_nxt    = 1'b0;
    mem_rd_req_nxt = mem_rd_req;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (int'(req_sel) >= NSRC) begin
            bus_err_nxt = 1'b1;
          end else if (req_sel == SEL_W'(MEM_SRC)) begin
            mem_rd_req_nxt = 1'b1;
            cnt_nxt        = '0;
            state_nxt      = ST_WAIT_MEM;
          end else begin
            bus_nxt       = ext_value;
            bus_src_nxt   = req_sel;
            bus_valid_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_MEM: begin
        // An ack on the timeout-boundary cycle still completes the read.
        if (mem_rd_ack) begin
          bus_nxt        = ext_value;
          bus_src_nxt    = SEL_W'(MEM_SRC);
          bus_valid_nxt  = 1'b1;
          mem_rd_req_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          bus_err_nxt    = 1'b1;
          mem_rd_req_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bus        <= '0;
      bus_src    <= '0;
      bus_valid  <= 1'b0;
      bus_err    <= 1'b0;
      mem_rd_req <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bus        <= bus_nxt;
      bus_src    <= bus_src_nxt;
      bus_valid  <= bus_valid_nxt;
      bus_err    <= bus_err_nxt;
      mem_rd_req <= mem_rd_req_nxt;
    end
  end

endmodule
